// File: rtl/pd_dw_nr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pd_dw_nr_pkg
//  Description : Shared constants, FSM state encoding and helper function for
//                the power-detect downlink NR scan block.
//  Revision    : 1.0  initial release
// ============================================================================
package pd_dw_nr_pkg;

    localparam int ANT_NUM        = 8;
    localparam int SYM_NUM        = 14;
    localparam int SLOT_MAX       = 10;
    localparam int ENTRY_PER_SLOT = ANT_NUM * SYM_NUM;
    localparam int RD_LAT         = 2;
    localparam int PWR_W          = 48;
    localparam int ADDR_W         = 11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_CLEAR = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Last address of a scan. Out-of-range slot counts (0 or >SLOT_MAX)
    // fall back to a full scan of SLOT_MAX slots.
    function automatic logic [ADDR_W-1:0] last_addr_f(input logic [3:0] num_slot);
        logic [3:0] w_slots;
        w_slots = ((num_slot == 4'd0) || (num_slot > 4'(SLOT_MAX))) ? 4'(SLOT_MAX) : num_slot;
        return ADDR_W'(w_slots) * ADDR_W'(ENTRY_PER_SLOT) - ADDR_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pd_dw_nr_scan_acc.sv
`default_nettype none
// ============================================================================
//  Module      : pd_dw_nr_scan_acc
//  Description : Compare / max / alarm / count datapath of the scan.
//                Accumulates one (address, power) pair per valid cycle.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                i_clr         - zero all results (scan start)
//                i_vld         - i_addr / i_pwr carry a captured entry
//                i_thresh      - alarm threshold (unsigned)
//                o_alarm       - per-antenna threshold flags
//                o_over_cnt    - count of entries >= threshold
//                o_max_pwr     - largest power seen
//                o_max_addr    - address of o_max_pwr (lowest on ties)
//  Revision    : 1.0  initial release
// ============================================================================
module pd_dw_nr_scan_acc
    import pd_dw_nr_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clr,
    input  logic               i_vld,
    input  logic [ADDR_W-1:0]  i_addr,
    input  logic [PWR_W-1:0]   i_pwr,
    input  logic [PWR_W-1:0]   i_thresh,
    output logic [ANT_NUM-1:0] o_alarm,
    output logic [ADDR_W-1:0]  o_over_cnt,
    output logic [PWR_W-1:0]   o_max_pwr,
    output logic [ADDR_W-1:0]  o_max_addr
);

    logic [ANT_NUM-1:0] r_alarm;
    logic [ADDR_W-1:0]  r_over_cnt;
    logic [PWR_W-1:0]   r_max_pwr;
    logic [ADDR_W-1:0]  r_max_addr;

    logic w_hit;
    logic w_new_max;

    assign w_hit     = (i_pwr >= i_thresh);
    // Strict compare keeps the first (lowest) address on equal power.
    assign w_new_max = (i_pwr > r_max_pwr);

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_alarm    <= '0;
            r_over_cnt <= '0;
            r_max_pwr  <= '0;
            r_max_addr <= '0;
        end else if (i_vld) begin
            if (w_hit) begin
                r_alarm[i_addr[2:0]] <= 1'b1;
                r_over_cnt           <= r_over_cnt + ADDR_W'(1);
            end
            if (w_new_max) begin
                r_max_pwr  <= i_pwr;
                r_max_addr <= i_addr;
            end
        end
    end

    assign o_alarm    = r_alarm;
    assign o_over_cnt = r_over_cnt;
    assign o_max_pwr  = r_max_pwr;
    assign o_max_addr = r_max_addr;

endmodule
`default_nettype wire

// File: rtl/pd_dw_nr_scan.sv
`default_nettype none
// ============================================================================
//  Module      : pd_dw_nr_scan
//  Description : Scans the power-detect storage (slot*112 + symbol*8 + ant),
//                reports per-antenna alarms, over-threshold count and the
//                peak power with its address, then optionally pulses a clear
//                to the storage.
//  Ports       : sys_clk, sys_rst      - clock, synchronous active-high reset
//                i_start               - scan start pulse (ignored when busy)
//                i_num_slot, i_thresh  - scan length / threshold, latched
//                o_pd_raddr            - storage read address
//                i_pd_rdata_lo/hi      - storage data, 2-cycle read latency
//                o_pd_clr              - storage clear pulse
//                o_busy, o_done        - scan status
//                o_alarm, o_over_cnt, o_max_pwr, o_max_addr - results
//  Config      : PD_DW_NR_SCAN_CLR_EN  - defined: CLEAR state and o_pd_clr
//                                        undefined: o_pd_clr tied 0
//  Revision    : 1.0  initial release
// ============================================================================
module pd_dw_nr_scan
    import pd_dw_nr_pkg::*;
(
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                i_start,
    input  logic [3:0]          i_num_slot,
    input  logic [PWR_W-1:0]    i_thresh,
    output logic [ADDR_W-1:0]   o_pd_raddr,
    input  logic [31:0]         i_pd_rdata_lo,
    input  logic [31:0]         i_pd_rdata_hi,
    output logic                o_pd_clr,
    output logic                o_busy,
    output logic                o_done,
    output logic [ANT_NUM-1:0]  o_alarm,
    output logic [ADDR_W-1:0]   o_over_cnt,
    output logic [PWR_W-1:0]    o_max_pwr,
    output logic [ADDR_W-1:0]   o_max_addr
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_busy;
    logic                w_done;
    logic                w_pd_clr;

    logic [ADDR_W-1:0]   r_pd_raddr;
    logic [ADDR_W-1:0]   r_last_addr;
    logic [PWR_W-1:0]    r_thresh;

    logic                w_start_acc;
    logic                w_rd_vld;
    logic                w_rd_last;
    logic                w_cap_last;

    // Address / valid / last markers delayed by the storage read latency so
    // each returned word is paired with the address that fetched it.
    logic [RD_LAT-1:0]   r_vld_pipe;
    logic [RD_LAT-1:0]   r_last_pipe;
    logic [ADDR_W-1:0]   r_addr_pipe [RD_LAT];

    // Upper half of the high data word carries no power bits.
    logic                w_unused_hi;
    assign w_unused_hi = ^i_pd_rdata_hi[31:16];

    assign w_start_acc = (r_state == ST_IDLE) && i_start;
    assign w_rd_vld    = (r_state == ST_READ);
    assign w_rd_last   = w_rd_vld && (r_pd_raddr == r_last_addr);
    assign w_cap_last  = r_vld_pipe[RD_LAT-1] && r_last_pipe[RD_LAT-1];

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_pd_clr    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                w_busy = 1'b1;
                if (w_rd_last) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_busy = 1'b1;
                if (w_cap_last) begin
`ifdef PD_DW_NR_SCAN_CLR_EN
                    w_state_nxt = ST_CLEAR;
`else
                    w_state_nxt = ST_DONE;
`endif
                end
            end
`ifdef PD_DW_NR_SCAN_CLR_EN
            ST_CLEAR: begin
                w_busy      = 1'b1;
                w_pd_clr    = 1'b1;
                w_state_nxt = ST_DONE;
            end
`endif
            ST_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Address generator; holds its value outside READ.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_pd_raddr  <= '0;
            r_last_addr <= '0;
            r_thresh    <= '0;
        end else if (w_start_acc) begin
            r_pd_raddr  <= '0;
            r_last_addr <= last_addr_f(i_num_slot);
            r_thresh    <= i_thresh;
        end else if (w_rd_vld && !w_rd_last) begin
            r_pd_raddr  <= r_pd_raddr + ADDR_W'(1);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_vld_pipe  <= '0;
            r_last_pipe <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_addr_pipe[i] <= '0;
            end
        end else begin
            r_vld_pipe     <= {r_vld_pipe[RD_LAT-2:0], w_rd_vld};
            r_last_pipe    <= {r_last_pipe[RD_LAT-2:0], w_rd_last};
            r_addr_pipe[0] <= r_pd_raddr;
            for (int i = 1; i < RD_LAT; i++) begin
                r_addr_pipe[i] <= r_addr_pipe[i-1];
            end
        end
    end

    pd_dw_nr_scan_acc u_acc (
        .clk        (sys_clk),
        .rst        (sys_rst),
        .i_clr      (w_start_acc),
        .i_vld      (r_vld_pipe[RD_LAT-1]),
        .i_addr     (r_addr_pipe[RD_LAT-1]),
        .i_pwr      ({i_pd_rdata_hi[15:0], i_pd_rdata_lo}),
        .i_thresh   (r_thresh),
        .o_alarm    (o_alarm),
        .o_over_cnt (o_over_cnt),
        .o_max_pwr  (o_max_pwr),
        .o_max_addr (o_max_addr)
    );

    assign o_pd_raddr = r_pd_raddr;
    assign o_pd_clr   = w_pd_clr;
    assign o_busy     = w_busy;
    assign o_done     = w_done;

endmodule
`default_nettype wire

// File: tb/tb_pd_dw_nr_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pd_dw_nr_scan
//  Description : Self-checking bench for pd_dw_nr_scan. A storage model with
//                2-cycle read latency feeds the DUT; a timeline/result model
//                derived from the scan rules is compared every cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pd_dw_nr_scan;

`ifdef PD_DW_NR_SCAN_CLR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        i_start = 1'b0;
    logic [3:0]  i_num_slot = 4'd0;
    logic [47:0] i_thresh = 48'd0;
    logic [10:0] o_pd_raddr;
    logic [31:0] i_pd_rdata_lo;
    logic [31:0] i_pd_rdata_hi;
    logic        o_pd_clr;
    logic        o_busy;
    logic        o_done;
    logic [7:0]  o_alarm;
    logic [10:0] o_over_cnt;
    logic [47:0] o_max_pwr;
    logic [10:0] o_max_addr;

    pd_dw_nr_scan dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .i_start       (i_start),
        .i_num_slot    (i_num_slot),
        .i_thresh      (i_thresh),
        .o_pd_raddr    (o_pd_raddr),
        .i_pd_rdata_lo (i_pd_rdata_lo),
        .i_pd_rdata_hi (i_pd_rdata_hi),
        .o_pd_clr      (o_pd_clr),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_alarm       (o_alarm),
        .o_over_cnt    (o_over_cnt),
        .o_max_pwr     (o_max_pwr),
        .o_max_addr    (o_max_addr)
    );

    always #2 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // ---------------- storage model ----------------
    logic [47:0] mem [0:2047];
    logic [47:0] rd_d1 = '0, rd_d2 = '0;
    logic [15:0] junk = '0;
    always @(posedge sys_clk) begin
        rd_d1 <= mem[o_pd_raddr];
        rd_d2 <= rd_d1;
        junk  <= 16'($urandom);
    end
    assign i_pd_rdata_lo = rd_d2[31:0];
    assign i_pd_rdata_hi = {junk, rd_d2[47:32]};

    // ---------------- checking ----------------
    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_k is the cycle index relative to the accepted start (start cycle = 0).
    bit          m_active = 1'b0;
    int          m_k = 0, m_n = 0, m_done_k = 0, m_slots = 0;
    logic [10:0] m_raddr_hold = '0;
    logic [7:0]  m_alarm = '0;
    logic [10:0] m_cnt = '0;
    logic [47:0] m_max = '0;
    logic [10:0] m_maxa = '0;

    always @(posedge sys_clk) begin
        if (sys_rst) begin
            m_active = 1'b0;
            m_raddr_hold = '0;
            m_alarm = '0; m_cnt = '0; m_max = '0; m_maxa = '0;
        end else if (m_active) begin
            if (m_k == m_done_k) begin
                m_active = 1'b0;
                m_raddr_hold = 11'(m_n - 1);
            end else begin
                m_k++;
            end
        end else if (i_start) begin
            m_slots  = (i_num_slot == 0 || i_num_slot > 10) ? 10 : int'(i_num_slot);
            m_n      = m_slots * 112;
            m_done_k = m_n + (CLR_EN ? 4 : 3);
            m_k      = 1;
            m_active = 1'b1;
            m_alarm = '0; m_cnt = '0; m_max = '0; m_maxa = '0;
            for (int a = 0; a < m_n; a++) begin
                if (mem[a] >= i_thresh) begin
                    m_alarm[a % 8] = 1'b1;
                    m_cnt++;
                end
                if (mem[a] > m_max) begin
                    m_max  = mem[a];
                    m_maxa = 11'(a);
                end
            end
        end
    end

    logic        e_busy, e_done, e_clr, res_chk, res_zero;
    logic [10:0] e_raddr;
    always @(negedge sys_clk) begin
        if (chk_en) begin
            if (m_active) begin
                e_busy   = (m_k < m_done_k);
                e_done   = (m_k == m_done_k);
                e_clr    = CLR_EN && (m_k == m_n + 3);
                e_raddr  = (m_k <= m_n) ? 11'(m_k - 1) : 11'(m_n - 1);
                res_chk  = (m_k == 1) || (m_k == m_done_k);
                res_zero = (m_k == 1);
            end else begin
                e_busy = 1'b0; e_done = 1'b0; e_clr = 1'b0;
                e_raddr = m_raddr_hold;
                res_chk = 1'b1; res_zero = 1'b0;
            end
            chk("busy", 64'(o_busy), 64'(e_busy));
            chk("done", 64'(o_done), 64'(e_done));
            chk("pd_clr", 64'(o_pd_clr), 64'(e_clr));
            chk("raddr", 64'(o_pd_raddr), 64'(e_raddr));
            if (res_chk) begin
                chk("alarm", 64'(o_alarm), res_zero ? 64'd0 : 64'(m_alarm));
                chk("over_cnt", 64'(o_over_cnt), res_zero ? 64'd0 : 64'(m_cnt));
                chk("max_pwr", 64'(o_max_pwr), res_zero ? 64'd0 : 64'(m_max));
                chk("max_addr", 64'(o_max_addr), res_zero ? 64'd0 : 64'(m_maxa));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic start_scan(input logic [3:0] ns, input logic [47:0] th, output int t);
        @(posedge sys_clk); #1;
        i_start = 1'b1; i_num_slot = ns; i_thresh = th;
        t = cyc;
        @(posedge sys_clk); #1;
        i_start = 1'b0;
        // Inputs must already be latched; scramble them.
        i_num_slot = 4'($urandom);
        i_thresh   = {16'($urandom), 32'($urandom)};
    endtask

    task automatic wait_done(input int t, output int d_off, output int c_off);
        bit seen;
        seen = 1'b0; d_off = -1; c_off = -1;
        for (int i = 0; i < 1300 && !seen; i++) begin
            @(posedge sys_clk); #1;
            if (o_pd_clr && c_off < 0) c_off = cyc - t;
            if (o_done) begin
                d_off = cyc - t;
                seen = 1'b1;
            end
        end
    endtask

    task automatic fill_const(input logic [47:0] v);
        for (int a = 0; a < 2048; a++) mem[a] = v;
    endtask

    task automatic fill_rand(input int mode);
        logic [63:0] r;
        for (int a = 0; a < 2048; a++) begin
            r = {$urandom, $urandom};
            case (mode)
                0: mem[a] = r[47:0];
                1: mem[a] = 48'($urandom_range(0, 7));
                default: mem[a] = {16'($urandom_range(0, 3)), 32'($urandom_range(0, 3))};
            endcase
        end
    endtask

    int t, d_off, c_off, extra, ns_i, n_exp;
    logic [47:0] th;

    initial begin
        fill_const(48'd0);
        @(posedge sys_clk); #1;
        chk_en = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1;
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_raddr", 64'(o_pd_raddr), 64'd0);
        chk("rst_max_pwr", 64'(o_max_pwr), 64'd0);
        sys_rst = 1'b0;

        // Single slot, one peak above threshold.
        fill_const(48'd500);
        mem[37] = 48'd2000;
        start_scan(4'd1, 48'd1000, t);
        wait_done(t, d_off, c_off);
        chk("s1_alarm", 64'(o_alarm), 64'h20);
        chk("s1_over_cnt", 64'(o_over_cnt), 64'd1);
        chk("s1_max_pwr", 64'(o_max_pwr), 64'd2000);
        chk("s1_max_addr", 64'(o_max_addr), 64'd37);
        chk("s1_done_lat", 64'(d_off), CLR_EN ? 64'd116 : 64'd115);
        chk("s1_clr_lat", 64'(c_off), CLR_EN ? 64'd115 : 64'hFFFF_FFFF_FFFF_FFFF);
        chk("model_s1_maxa", 64'(m_maxa), 64'd37);
        repeat (3) @(posedge sys_clk);

        // Full scan via num_slot=0, data = address, threshold 0.
        for (int a = 0; a < 2048; a++) mem[a] = 48'(a);
        start_scan(4'd0, 48'd0, t);
        wait_done(t, d_off, c_off);
        chk("full_alarm", 64'(o_alarm), 64'hFF);
        chk("full_over_cnt", 64'(o_over_cnt), 64'd1120);
        chk("full_max_addr", 64'(o_max_addr), 64'd1119);
        chk("full_max_pwr", 64'(o_max_pwr), 64'd1119);
        chk("full_clr_lat", 64'(c_off), CLR_EN ? 64'd1123 : 64'hFFFF_FFFF_FFFF_FFFF);
        chk("model_full_cnt", 64'(m_cnt), 64'd1120);

        // Tie on a value that lives only in the hi word.
        fill_const(48'd0);
        mem[5] = 48'h0001_0000_0000;
        mem[200] = 48'h0001_0000_0000;
        start_scan(4'd2, 48'hFFFF_FFFF_FFFF, t);
        wait_done(t, d_off, c_off);
        chk("tie_max_addr", 64'(o_max_addr), 64'd5);
        chk("tie_max_pwr", 64'(o_max_pwr), 64'h0001_0000_0000);
        chk("tie_over_cnt", 64'(o_over_cnt), 64'd0);
        chk("tie_alarm", 64'(o_alarm), 64'd0);

        // Second start while busy is ignored.
        fill_rand(1);
        start_scan(4'd3, 48'd4, t);
        repeat (40) @(posedge sys_clk);
        #1;
        i_start = 1'b1; i_num_slot = 4'd1; i_thresh = 48'd0;
        @(posedge sys_clk); #1;
        i_start = 1'b0;
        wait_done(t, d_off, c_off);
        chk("restart_done_lat", 64'(d_off), CLR_EN ? 64'd340 : 64'd339);
        extra = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge sys_clk); #1;
            if (o_done) extra++;
        end
        chk("restart_extra_done", 64'(extra), 64'd0);

        // Reset in the middle of a scan.
        fill_rand(0);
        start_scan(4'd2, mem[17], t);
        for (int i = 0; i < 100 && cyc != t + 50; i++) begin
            @(posedge sys_clk); #1;
        end
        sys_rst = 1'b1;
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        chk("abort_busy", 64'(o_busy), 64'd0);
        chk("abort_cnt", 64'(o_over_cnt), 64'd0);
        chk("abort_alarm", 64'(o_alarm), 64'd0);
        extra = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge sys_clk); #1;
            if (o_done || o_pd_clr) extra++;
        end
        chk("abort_no_done_clr", 64'(extra), 64'd0);
        start_scan(4'd1, mem[3], t);
        wait_done(t, d_off, c_off);
        chk("post_abort_done_lat", 64'(d_off), CLR_EN ? 64'd116 : 64'd115);

        // Randomized scans, some back-to-back.
        for (int it = 0; it < 6; it++) begin
            fill_rand(it % 3);
            ns_i = $urandom_range(0, 15);
            th = ($urandom_range(0, 3) == 0) ? {16'($urandom), 32'($urandom)}
                                              : mem[$urandom_range(0, 111)];
            start_scan(4'(ns_i), th, t);
            wait_done(t, d_off, c_off);
            n_exp = ((ns_i == 0 || ns_i > 10) ? 10 : ns_i) * 112;
            chk("rand_done_lat", 64'(d_off), 64'(n_exp + (CLR_EN ? 4 : 3)));
            repeat ($urandom_range(0, 3)) @(posedge sys_clk);
        end

        repeat (4) @(posedge sys_clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pd_dw_nr_scan.md
PD_DW_NR_SCAN -- requirements
Module: pd_dw_nr_scan

Interface
REQ-001 The block SHALL have one clock, sys_clk; reset is synchronous and active-high, sys_rst.
REQ-002 The block SHALL have these ports:
- sys_clk  in  1  system clock, 245.76 MHz.
- sys_rst  in  1  synchronous active-high reset.
- i_start  in  1  one-cycle pulse that starts a scan.
- i_num_slot  in  4  number of slots to scan; 1..10 valid.
- i_thresh  in  48  alarm threshold (unsigned power).
- o_pd_raddr  out  11  read address to the power-detect storage.
- i_pd_rdata_lo  in  32  power bits [31:0].
- i_pd_rdata_hi  in  32  bits [15:0] are power bits [47:32]; bits [31:16] are ignored.
- o_pd_clr  out  1  one-cycle clear pulse to the storage.
- o_busy  out  1  high while a scan is running.
- o_done  out  1  one-cycle pulse; results are valid from this cycle.
- o_alarm  out  8  per-antenna flag; set if any entry for that antenna is >= i_thresh.
- o_over_cnt  out  11  number of entries >= i_thresh.
- o_max_pwr  out  48  largest power value in the scan.
- o_max_addr  out  11  address of o_max_pwr.

Function
REQ-003 The address map SHALL be addr = slot*112 + symbol*8 + ant (ant 0..7, symbol 0..13, slot 0..9); the entry's antenna is addr[2:0].
REQ-004 Storage read latency SHALL be fixed at 2 cycles: data for o_pd_raddr driven in cycle t is on i_pd_rdata_* in cycle t+2.
REQ-005 The FSM SHALL have five states: IDLE, READ, DRAIN, CLEAR, DONE.
REQ-006 State transitions SHALL be:
- IDLE to READ on i_start.
- READ to DRAIN after the last address is issued.
- DRAIN to CLEAR (or to DONE without the clear feature) after the last data is captured.
- CLEAR to DONE after one cycle.
- DONE to IDLE after one cycle.
REQ-007 When i_start is seen in IDLE, the block SHALL latch i_num_slot and i_thresh, and in the next cycle SHALL set o_busy=1, clear all result outputs to 0, and drive o_pd_raddr=0.
REQ-008 In READ, o_pd_raddr SHALL increment by 1 every cycle from 0 to N-1, where N = num_slot*112; there are no gaps.
REQ-009 If the latched i_num_slot is 0 or greater than 10, it SHALL be treated as 10 (N=1120).
REQ-010 For each returned word P={hi[15:0],lo}, the block SHALL compare unsigned and act as follows:
- if P >= thresh: set o_alarm[addr[2:0]] and increment o_over_cnt;
- if P > o_max_pwr: update o_max_pwr and o_max_addr. On ties the lowest address is kept.
REQ-011 A pipeline copy of the address SHALL be delayed 2 cycles so that each data word is paired with its own address.
REQ-012 o_pd_clr SHALL be asserted for exactly the one CLEAR cycle, after the last data word has been captured.
REQ-013 o_done SHALL be high only in DONE, and o_busy SHALL fall in the same cycle.
REQ-014 Results SHALL hold until the next accepted i_start.
REQ-015 Latency SHALL be: i_start in cycle T gives the last address at T+N, the last capture at T+N+2, o_pd_clr at T+N+3, and o_done at T+N+4.
REQ-016 An i_start that arrives outside IDLE SHALL be ignored, with no restart and no queuing.
REQ-017 o_over_cnt SHALL NOT saturate, because N<=1120 fits in 11 bits.
REQ-018 Outside READ, o_pd_raddr SHALL hold its last value.

Reset
REQ-019 sys_rst SHALL put the FSM in IDLE and drive every output to 0.
REQ-020 A reset during a scan SHALL abort the scan at once: no o_done and no o_pd_clr are produced, and results are 0.
REQ-021 The first i_start after reset release SHALL be accepted normally.

Configuration
REQ-022 Macro PD_DW_NR_SCAN_CLR_EN:
- defined: the CLEAR state exists and o_pd_clr behaves per REQ-012;
- undefined: CLEAR is removed, o_pd_clr is tied 0, and o_done arrives at T+N+3.

Structure
REQ-023 A shared package pd_dw_nr_pkg SHALL hold:
- the constants ANT_NUM=8, SYM_NUM=14, SLOT_MAX=10, ENTRY_PER_SLOT=112, RD_LAT=2, PWR_W=48, ADDR_W=11;
- the FSM state typedef.
REQ-024 There SHALL be one sub-module, pd_dw_nr_scan_acc, containing the compare/max/alarm/count datapath; the FSM and address generator stay in the top level.

Verification
REQ-025 Single slot: num_slot=1, thresh=1000, all entries 500 except addr 37 = 2000 -> o_alarm=8'h20, o_over_cnt=1, o_max_pwr=2000, o_max_addr=37, o_done at T+116 (clear on).
REQ-026 Full scan: num_slot=0 -> 1120 reads; stored data = addr; thresh=0 -> o_alarm=8'hFF, o_over_cnt=1120, o_max_addr=1119, o_pd_clr at T+1123.
REQ-027 Tie plus hi bits: num_slot=2, entries 5 and 200 both 48'h0001_0000_0000 (hi=1, lo=0), others 0, thresh=max -> o_max_addr=5, o_over_cnt=0, o_alarm=0.
REQ-028 Busy restart: second i_start mid-scan -> ignored; a single o_done; results match the first scan only.
REQ-029 Reset mid-scan: sys_rst at T+50 for 1 cycle -> all outputs 0, no o_pd_clr, no o_done; a new i_start then completes normally.
REQ-030 Macro undefined: repeat REQ-025 -> o_pd_clr never asserted, o_done at T+115.
